pipe_hazard_ctrl: RTL and testbench

// Parametrised hazard/forwarding controller for the 5-stage 16-bit CPU pipeline (F/D/E/M/W).

---
 rtl/cpu_pipe_pkg.sv | 23 ++
 rtl/pipe_sat_counter.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared types for the 5-stage pipeline hazard controller: forwarding selects and the
// per-stage destination record kept in the shadow pipeline.
package cpu_pipe_pkg;

  // Widest register address a shadow stage can hold; narrower addresses are zero-extended.
  localparam int unsigned MAX_REG_AW = 8;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic                  valid;
    logic [MAX_REG_AW-1:0] dst;
    logic                  wr_en;
    logic                  is_load;
  } stage_info_t;

  localparam stage_info_t NOP_STAGE = '{valid: 1'b0, dst: '0, wr_en: 1'b0, is_load: 1'b0};

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter with asynchronous active-low clear; sticks at all-ones.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the F/D/E/M/W pipeline: tracks E/M/W destinations,
// raises stall/flush/bubble controls and registers per-operand forwarding selects for E.
module pipe_hazard_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned REG_AW      = 4,
  parameter int unsigned NSRC        = 3,
  parameter int unsigned ZERO_REG_EN = 0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   d_valid_i,
  input  logic [NSRC*REG_AW-1:0] d_src_addr_i,
  input  logic [NSRC-1:0]        d_src_used_i,
  input  logic [REG_AW-1:0]      d_dst_addr_i,
  input  logic                   d_wr_en_i,
  input  logic                   d_is_load_i,
  input  logic                   e_branch_taken_i,
  input  logic                   m_busy_i,
  output logic                   stall_f_o,
  output logic                   stall_d_o,
  output logic                   stall_em_o,
  output logic                   flush_d_o,
  output logic                   bubble_e_o,
  output logic                   bubble_w_o,
  output logic [2*NSRC-1:0]      fwd_sel_o,
  output logic [CNT_W-1:0]       cnt_loaduse_o,
  output logic [CNT_W-1:0]       cnt_flush_o,
  output logic [CNT_W-1:0]       cnt_membusy_o
);

  stage_info_t e_q, m_q, w_q;
  stage_info_t e_d, m_d, w_d;
  stage_info_t d_info;
  logic [2*NSRC-1:0] fwd_q, fwd_d, fwd_next;
  logic [NSRC-1:0]   match_e, match_m;
  logic              busy, branch, load_use;

  assign d_info = '{valid:   d_valid_i,
                    dst:     MAX_REG_AW'(d_dst_addr_i),
                    wr_en:   d_wr_en_i,
                    is_load: d_is_load_i};

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    logic [MAX_REG_AW-1:0] src;
    logic                  zero_blk;
    fwd_sel_e              sel;

    assign src      = MAX_REG_AW'(d_src_addr_i[k*REG_AW +: REG_AW]);
    assign zero_blk = (ZERO_REG_EN != 0) && (src == '0);

    assign match_e[k] = e_q.valid & e_q.wr_en & d_src_used_i[k] & (src == e_q.dst) & ~zero_blk;
    assign match_m[k] = m_q.valid & m_q.wr_en & d_src_used_i[k] & (src == m_q.dst) & ~zero_blk;

    // A load in E has no data yet, so only an older match in M can forward.
    assign sel = (match_e[k] && !e_q.is_load) ? FWD_MEM :
                 match_m[k]                   ? FWD_WB  : FWD_RF;
    assign fwd_next[2*k +: 2] = sel;
  end

  assign busy     = m_busy_i;
  assign branch   = e_branch_taken_i & ~busy;
  assign load_use = d_valid_i & e_q.is_load & (|match_e) & ~busy & ~e_branch_taken_i;

  // Controls are forced low while reset is asserted, regardless of inputs.
  assign stall_f_o  = rst & (busy | load_use);
  assign stall_d_o  = rst & (busy | load_use);
  assign stall_em_o = rst & busy;
  assign flush_d_o  = rst & branch;
  assign bubble_e_o = rst & (branch | load_use);
  assign bubble_w_o = rst & busy;

  always_comb begin
    e_d   = e_q;
    m_d   = m_q;
    w_d   = w_q;
    fwd_d = fwd_q;
    if (busy) begin
      w_d = NOP_STAGE;
    end else if (branch || load_use) begin
      e_d   = NOP_STAGE;
      m_d   = e_q;
      w_d   = m_q;
      fwd_d = '0;
    end else begin
      e_d   = d_info;
      m_d   = e_q;
      w_d   = m_q;
      fwd_d = fwd_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_q   <= NOP_STAGE;
      m_q   <= NOP_STAGE;
      w_q   <= NOP_STAGE;
      fwd_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      fwd_q <= fwd_d;
    end
  end

  assign fwd_sel_o = fwd_q;

  // W needs no forwarding path: the regfile writes on the falling edge.
  logic unused_w;
  assign unused_w = ^w_q;

  pipe_sat_counter #(.CNT_W(CNT_W)) u_cnt_loaduse (
    .clk_i  (clk),
    .rst_ni (rst),
    .inc_i  (load_use),
    .count_o(cnt_loaduse_o)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_cnt_flush (
    .clk_i  (clk),
    .rst_ni (rst),
    .inc_i  (branch),
    .count_o(cnt_flush_o)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_cnt_membusy (
    .clk_i  (clk),
    .rst_ni (rst),
    .inc_i  (busy),
    .count_o(cnt_membusy_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic on a default instance
// and a ZERO_REG_EN=1 / CNT_W=4 instance, each checked against a behavioural pipeline model.
module tb_pipe_hazard_ctrl;

  localparam int AW = 4;
  localparam int NS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        d_valid = 1'b0;
  logic [11:0] d_src = '0;
  logic [2:0]  d_used = '0;
  logic [3:0]  d_dst = '0;
  logic        d_wr = 1'b0, d_load = 1'b0, br = 1'b0, busy = 1'b0;

  logic sf_a, sd_a, sem_a, fd_a, be_a, bw_a;
  logic sf_b, sd_b, sem_b, fd_b, be_b, bw_b;
  logic [5:0]  fwd_a, fwd_b;
  logic [15:0] clu_a, cfl_a, cmb_a;
  logic [3:0]  clu_b, cfl_b, cmb_b;
  logic [5:0]  ctl_a, ctl_b;

  assign ctl_a = {sf_a, sd_a, sem_a, fd_a, be_a, bw_a};
  assign ctl_b = {sf_b, sd_b, sem_b, fd_b, be_b, bw_b};

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut_a (
    .clk(clk), .rst(rst), .d_valid_i(d_valid), .d_src_addr_i(d_src), .d_src_used_i(d_used),
    .d_dst_addr_i(d_dst), .d_wr_en_i(d_wr), .d_is_load_i(d_load), .e_branch_taken_i(br),
    .m_busy_i(busy), .stall_f_o(sf_a), .stall_d_o(sd_a), .stall_em_o(sem_a),
    .flush_d_o(fd_a), .bubble_e_o(be_a), .bubble_w_o(bw_a), .fwd_sel_o(fwd_a),
    .cnt_loaduse_o(clu_a), .cnt_flush_o(cfl_a), .cnt_membusy_o(cmb_a)
  );

  pipe_hazard_ctrl #(.ZERO_REG_EN(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .d_valid_i(d_valid), .d_src_addr_i(d_src), .d_src_used_i(d_used),
    .d_dst_addr_i(d_dst), .d_wr_en_i(d_wr), .d_is_load_i(d_load), .e_branch_taken_i(br),
    .m_busy_i(busy), .stall_f_o(sf_b), .stall_d_o(sd_b), .stall_em_o(sem_b),
    .flush_d_o(fd_b), .bubble_e_o(be_b), .bubble_w_o(bw_b), .fwd_sel_o(fwd_b),
    .cnt_loaduse_o(clu_b), .cnt_flush_o(cfl_b), .cnt_membusy_o(cmb_b)
  );

  // Behavioural model: index 0 mirrors dut_a, index 1 mirrors dut_b.
  typedef struct {bit v; int dst; bit wr; bit ld;} st_t;
  st_t pe[2], pm[2], pw[2];
  int  fw[2][NS];
  int  clu[2], cfl[2], cmb[2];
  int  cmax[2];
  bit  zen[2];
  int  checks = 0;
  int  failures = 0;

  function automatic int src_of(int k);
    return int'((d_src >> (AW * k)) & 12'hF);
  endfunction

  function automatic bit hit(int i, int k, st_t s);
    return s.v && s.wr && d_used[k] && (src_of(k) == s.dst) && !(zen[i] && src_of(k) == 0);
  endfunction

  function automatic bit lu_now(int i);
    bit any = 0;
    for (int k = 0; k < NS; k++) any |= hit(i, k, pe[i]);
    return !busy && !br && d_valid && pe[i].ld && any;
  endfunction

  // {stall_f, stall_d, stall_em, flush_d, bubble_e, bubble_w}
  function automatic logic [5:0] exp_ctl(int i);
    if (!rst) return 6'b000000;
    if (busy) return 6'b111001;
    if (br) return 6'b000110;
    if (lu_now(i)) return 6'b110010;
    return 6'b000000;
  endfunction

  function automatic logic [5:0] exp_fwd(int i);
    logic [5:0] r;
    for (int k = 0; k < NS; k++) r[2*k +: 2] = 2'(fw[i][k]);
    return r;
  endfunction

  task automatic model_reset;
    st_t nop = '{0, 0, 0, 0};
    for (int i = 0; i < 2; i++) begin
      pe[i] = nop; pm[i] = nop; pw[i] = nop;
      for (int k = 0; k < NS; k++) fw[i][k] = 0;
      clu[i] = 0; cfl[i] = 0; cmb[i] = 0;
    end
  endtask

  task automatic model_edge;
    st_t nop = '{0, 0, 0, 0};
    st_t din;
    din = '{d_valid, int'(d_dst), d_wr, d_load};
    for (int i = 0; i < 2; i++) begin
      if (busy) begin
        pw[i] = nop;
        if (cmb[i] < cmax[i]) cmb[i]++;
      end else if (br || lu_now(i)) begin
        if (br) begin
          if (cfl[i] < cmax[i]) cfl[i]++;
        end else if (clu[i] < cmax[i]) clu[i]++;
        for (int k = 0; k < NS; k++) fw[i][k] = 0;
        pw[i] = pm[i]; pm[i] = pe[i]; pe[i] = nop;
      end else begin
        for (int k = 0; k < NS; k++)
          fw[i][k] = (hit(i, k, pe[i]) && !pe[i].ld) ? 1 : hit(i, k, pm[i]) ? 2 : 0;
        pw[i] = pm[i]; pm[i] = pe[i]; pe[i] = din;
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    if (rst) model_edge();
    #1;
  endtask

  task automatic set_d(bit v, int s0, int s1, int s2, logic [2:0] used, int dst, bit wr, bit ld);
    d_valid = v; d_src = {4'(s2), 4'(s1), 4'(s0)}; d_used = used;
    d_dst = 4'(dst); d_wr = wr; d_load = ld;
  endtask

  task automatic idle;
    set_d(0, 0, 0, 0, 3'b000, 0, 0, 0);
    br = 0; busy = 0;
  endtask

  task automatic do_reset;
    rst = 0; model_reset();
    #2;
    rst = 1;
  endtask

  task automatic test_reset;
    set_d(1, 1, 2, 3, 3'b111, 4, 1, 1);
    br = 1; busy = 1;
    #1;
    checks++; if (ctl_a !== 6'b0) begin failures++; $display("FAIL reset_ctl_a got %b exp 000000", ctl_a); end
    checks++; if (ctl_b !== 6'b0) begin failures++; $display("FAIL reset_ctl_b got %b exp 000000", ctl_b); end
    checks++; if (fwd_a !== 6'b0) begin failures++; $display("FAIL reset_fwd got %b exp 000000", fwd_a); end
    checks++;
    if ({clu_a, cfl_a, cmb_a} !== 48'b0) begin
      failures++; $display("FAIL reset_cnt got %0h/%0h/%0h exp 0", clu_a, cfl_a, cmb_a);
    end
    idle();
    do_reset();
  endtask

  task automatic test_raw_fwd;
    do_reset();
    set_d(1, 0, 0, 0, 3'b000, 1, 1, 0);  // ADD r1
    tick();
    set_d(1, 1, 0, 0, 3'b001, 5, 1, 0);  // reads r1 on op0
    #1;
    checks++; if (ctl_a !== 6'b0) begin failures++; $display("FAIL raw_nostall got %b exp 000000", ctl_a); end
    tick();
    checks++; if (fwd_a[1:0] !== 2'd1) begin failures++; $display("FAIL raw_fwd_m got %0d exp 1", fwd_a[1:0]); end
    set_d(1, 0, 0, 0, 3'b000, 6, 1, 0);  // ADD r6
    tick();
    set_d(1, 0, 0, 0, 3'b000, 0, 0, 0);  // unrelated
    tick();
    set_d(1, 6, 0, 0, 3'b001, 7, 1, 0);  // reads r6 one instr later
    tick();
    checks++; if (fwd_a[1:0] !== 2'd2) begin failures++; $display("FAIL raw_fwd_w got %0d exp 2", fwd_a[1:0]); end
    idle();
  endtask

  task automatic test_load_use;
    do_reset();
    set_d(1, 0, 0, 0, 3'b000, 2, 1, 1);  // LOAD r2
    tick();
    set_d(1, 0, 2, 0, 3'b010, 8, 1, 0);  // reads r2 on op1
    #1;
    checks++; if (ctl_a !== 6'b110010) begin failures++; $display("FAIL lu_stall got %b exp 110010", ctl_a); end
    tick();
    checks++; if (ctl_a !== 6'b0) begin failures++; $display("FAIL lu_one_cycle got %b exp 000000", ctl_a); end
    tick();
    checks++; if (fwd_a[3:2] !== 2'd2) begin failures++; $display("FAIL lu_fwd got %0d exp 2", fwd_a[3:2]); end
    checks++; if (clu_a !== 16'd1) begin failures++; $display("FAIL lu_cnt got %0d exp 1", clu_a); end
    idle();
  endtask

  task automatic test_double_match;
    do_reset();
    set_d(1, 0, 0, 0, 3'b000, 3, 1, 0);
    tick();
    set_d(1, 0, 0, 0, 3'b000, 3, 1, 0);
    tick();
    set_d(1, 0, 0, 3, 3'b100, 9, 1, 0);  // reads r3 on op2
    tick();
    checks++; if (fwd_a[5:4] !== 2'd1) begin failures++; $display("FAIL dbl_youngest got %0d exp 1", fwd_a[5:4]); end
    idle();
  endtask

  task automatic test_branch_vs_loaduse;
    do_reset();
    set_d(1, 0, 0, 0, 3'b000, 2, 1, 1);
    tick();
    set_d(1, 2, 0, 0, 3'b001, 4, 1, 0);
    br = 1;
    #1;
    checks++; if (ctl_a !== 6'b000110) begin failures++; $display("FAIL br_lu_ctl got %b exp 000110", ctl_a); end
    tick();
    idle();
    checks++; if (cfl_a !== 16'd1) begin failures++; $display("FAIL br_lu_flush got %0d exp 1", cfl_a); end
    checks++; if (clu_a !== 16'd0) begin failures++; $display("FAIL br_lu_lucnt got %0d exp 0", clu_a); end
  endtask

  task automatic test_busy_branch;
    do_reset();
    set_d(1, 0, 0, 0, 3'b000, 4, 1, 0);
    tick();
    br = 1; busy = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (ctl_a !== 6'b111001) begin failures++; $display("FAIL busy_ctl[%0d] got %b exp 111001", c, ctl_a); end
      tick();
    end
    busy = 0;
    #1;
    checks++; if (ctl_a !== 6'b000110) begin failures++; $display("FAIL busy_then_br got %b exp 000110", ctl_a); end
    tick();
    idle();
    checks++; if (cmb_a !== 16'd3) begin failures++; $display("FAIL busy_cnt got %0d exp 3", cmb_a); end
    checks++; if (cfl_a !== 16'd1) begin failures++; $display("FAIL busy_flush got %0d exp 1", cfl_a); end
  endtask

  task automatic test_zero_reg;
    do_reset();
    set_d(1, 0, 0, 0, 3'b000, 0, 1, 0);  // ADD r0
    tick();
    set_d(1, 0, 0, 0, 3'b001, 5, 1, 0);  // reads r0
    tick();
    checks++; if (fwd_b !== 6'b0) begin failures++; $display("FAIL zero_fwd got %b exp 000000", fwd_b); end
    checks++; if (fwd_a[1:0] !== 2'd1) begin failures++; $display("FAIL nozero_fwd got %0d exp 1", fwd_a[1:0]); end
    set_d(1, 0, 0, 0, 3'b000, 0, 1, 1);  // LOAD r0
    tick();
    set_d(1, 0, 0, 0, 3'b001, 5, 1, 0);
    #1;
    checks++; if (ctl_b !== 6'b0) begin failures++; $display("FAIL zero_nostall got %b exp 000000", ctl_b); end
    checks++; if (ctl_a !== 6'b110010) begin failures++; $display("FAIL nozero_stall got %b exp 110010", ctl_a); end
    tick();
    idle();
  endtask

  task automatic test_async_reset;
    do_reset();
    set_d(1, 0, 0, 0, 3'b000, 2, 1, 1);
    tick();
    set_d(1, 2, 0, 0, 3'b001, 4, 1, 0);
    busy = 1;
    #2;
    rst = 0; model_reset();
    #1;
    checks++; if (ctl_a !== 6'b0) begin failures++; $display("FAIL arst_ctl_a got %b exp 000000", ctl_a); end
    checks++; if (ctl_b !== 6'b0) begin failures++; $display("FAIL arst_ctl_b got %b exp 000000", ctl_b); end
    checks++; if (cmb_a !== 16'd0) begin failures++; $display("FAIL arst_cnt got %0d exp 0", cmb_a); end
    busy = 0;
    rst = 1;
    #1;
    checks++; if (ctl_a !== 6'b0) begin failures++; $display("FAIL arst_after_ctl got %b exp 000000", ctl_a); end
    tick();
    checks++; if (fwd_a !== 6'b0) begin failures++; $display("FAIL arst_after_fwd got %b exp 000000", fwd_a); end
    idle();
  endtask

  task automatic test_saturation;
    do_reset();
    for (int n = 0; n < 20; n++) begin
      set_d(1, 0, 0, 0, 3'b000, 2, 1, 1);
      tick();
      set_d(1, 2, 0, 0, 3'b001, 6, 0, 0);
      tick();
      tick();
    end
    idle();
    checks++; if (clu_b !== 4'd15) begin failures++; $display("FAIL sat_cnt4 got %0d exp 15", clu_b); end
    checks++; if (clu_a !== 16'd20) begin failures++; $display("FAIL sat_cnt16 got %0d exp 20", clu_a); end
  endtask

  task automatic test_random;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      set_d(($urandom % 4) != 0, $urandom % 4, $urandom % 4, $urandom % 4, 3'($urandom),
            $urandom % 4, $urandom % 2, ($urandom % 3) == 0);
      br = ($urandom % 8) == 0;
      busy = ($urandom % 6) == 0;
      #1;
      checks++;
      if (ctl_a !== exp_ctl(0)) begin
        failures++; $display("FAIL rnd_ctl_a cyc %0d got %b exp %b", c, ctl_a, exp_ctl(0));
      end
      checks++;
      if (ctl_b !== exp_ctl(1)) begin
        failures++; $display("FAIL rnd_ctl_b cyc %0d got %b exp %b", c, ctl_b, exp_ctl(1));
      end
      tick();
      checks++;
      if (fwd_a !== exp_fwd(0)) begin
        failures++; $display("FAIL rnd_fwd_a cyc %0d got %b exp %b", c, fwd_a, exp_fwd(0));
      end
      checks++;
      if (fwd_b !== exp_fwd(1)) begin
        failures++; $display("FAIL rnd_fwd_b cyc %0d got %b exp %b", c, fwd_b, exp_fwd(1));
      end
      checks++;
      if ({clu_a, cfl_a, cmb_a} !== {16'(clu[0]), 16'(cfl[0]), 16'(cmb[0])}) begin
        failures++;
        $display("FAIL rnd_cnt_a cyc %0d got %0d/%0d/%0d exp %0d/%0d/%0d", c, clu_a, cfl_a, cmb_a,
                 clu[0], cfl[0], cmb[0]);
      end
      checks++;
      if ({clu_b, cfl_b, cmb_b} !== {4'(clu[1]), 4'(cfl[1]), 4'(cmb[1])}) begin
        failures++;
        $display("FAIL rnd_cnt_b cyc %0d got %0d/%0d/%0d exp %0d/%0d/%0d", c, clu_b, cfl_b, cmb_b,
                 clu[1], cfl[1], cmb[1]);
      end
    end
    idle();
  endtask

  initial begin
    cmax[0] = 65535; cmax[1] = 15;
    zen[0] = 0; zen[1] = 1;
    model_reset();
    test_reset();
    test_raw_fwd();
    test_load_use();
    test_double_match();
    test_branch_vs_loaduse();
    test_busy_branch();
    test_zero_reg();
    test_async_reset();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
